// File: rtl/fetch_pkg.sv
// Shared fetch-unit types and constants: state encoding, PC width/increment, buffer entry layout.
package fetch_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two fetch buffer with push/pop/flush; the head entry is read straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic [CNT_W-1:0] count,
  output logic             not_empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nx;

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + CNT_W'(1);
      2'b01:   count_nx = count - CNT_W'(1);
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      not_empty <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      not_empty <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nx;
      not_empty <= (count_nx != '0);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetcher with a small decoupling buffer and redirect support.
// Optional FETCH_ALIGN_CHECK_EN turns misaligned redirect targets into a sticky fault.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign_fault
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_t     state_q, state_nx;
  logic [PC_W-1:0]  pc_q, pc_nx;
  logic             fault_q, fault_nx;
  logic             push, pop, flush, pop_ok, has_room;
  logic [CNT_W-1:0] count;
  logic             not_empty;
  fetch_entry_t     head;
  fetch_entry_t     fetched;

  assign fetched  = '{inst: imem_dout, pc: pc_q};
  assign pop_ok   = not_empty && inst_ready;
  assign has_room = (count < CNT_W'(BUF_DEPTH)) || pop_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      pc_q    <= pc_nx;
      fault_q <= fault_nx;
    end
  end

  // Redirect outranks everything: flush, drop this cycle's push and pop, retarget.
  always_comb begin
    state_nx = state_q;
    pc_nx    = pc_q;
    fault_nx = fault_q;
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_nx = FAULT;
        fault_nx = 1'b1;
      end else begin
        state_nx = FETCH;
        pc_nx    = redirect_pc;
        fault_nx = 1'b0;
      end
`else
      state_nx = FETCH;
      pc_nx    = redirect_pc & ~32'h3;
`endif
    end else begin
      case (state_q)
        FETCH: begin
          pop = pop_ok;
          if (has_room) begin
            push  = 1'b1;
            pc_nx = pc_q + PC_INC;
          end else begin
            state_nx = FULL;
          end
        end
        FULL: begin
          pop = pop_ok;
          if (pop_ok) state_nx = FETCH;
        end
        FAULT:   state_nx = FAULT;
        default: state_nx = FETCH;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .din       (fetched),
    .dout      (head),
    .count     (count),
    .not_empty (not_empty)
  );

  assign imem_addr      = pc_q;
  assign inst_valid     = not_empty;
  assign inst           = head.inst;
  assign inst_pc        = head.pc;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; a second instance checks PC wrap from a high RESET_PC.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        misalign_fault;

  logic [31:0] w_imem_addr, w_imem_dout;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_inst_valid, w_inst_ready;
  logic [31:0] w_inst, w_inst_pc;
  logic        w_misalign_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory image: word index tagged so each address returns a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h8000_0000 ^ (addr >> 2);
  endfunction

  assign imem_dout   = mem_word(imem_addr);
  assign w_imem_dout = mem_word(w_imem_addr);

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .misalign_fault(misalign_fault)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_dout(w_imem_dout),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst),
    .inst_pc(w_inst_pc), .misalign_fault(w_misalign_fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    inst_ready     = 1'b0;
    w_inst_ready   = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1;
    check_eq("rst_valid", 32'(inst_valid), 32'h0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    check_eq("rst_fault", 32'(misalign_fault), 32'h0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);

    // Streaming with the consumer always ready.
    @(negedge clk);
    @(negedge clk);
    reset      = 1'b0;
    inst_ready = 1'b1;
    tick();
    check_eq("s0_valid", 32'(inst_valid), 32'h1);
    check_eq("s0_pc", inst_pc, 32'h0);
    check_eq("s0_inst", inst, mem_word(32'h0));
    check_eq("w0_pc", w_inst_pc, 32'hFFFF_FFF8);
    tick();
    check_eq("s1_pc", inst_pc, 32'h4);
    check_eq("w1_pc", w_inst_pc, 32'hFFFF_FFFC);
    tick();
    check_eq("s2_pc", inst_pc, 32'h8);
    check_eq("s2_inst", inst, mem_word(32'h8));
    check_eq("w2_pc", w_inst_pc, 32'h0);
    check_eq("w2_inst", w_inst, mem_word(32'h0));

    // Backpressure: restart at 0 and stall the consumer until the buffer fills.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    tick();
    check_eq("bp_flush_valid", 32'(inst_valid), 32'h0);
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("bp_count", 32'(dut.count), 32'd2);
    check_eq("bp_state", 32'(dut.state_q), 32'(FULL));
    check_eq("bp_addr", imem_addr, 32'h8);
    check_eq("bp_head", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick();
    check_eq("bp_pop1", inst_pc, 32'h4);
    check_eq("bp_state_back", 32'(dut.state_q), 32'(FETCH));
    tick();
    check_eq("bp_pop2", inst_pc, 32'h8);
    check_eq("bp_pop2_inst", inst, mem_word(32'h8));

    // Redirect while full must leave no stale entries.
    inst_ready = 1'b0;
    tick();
    tick();
    check_eq("rd_full", 32'(dut.state_q), 32'(FULL));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    check_eq("rd_valid0", 32'(inst_valid), 32'h0);
    check_eq("rd_addr", imem_addr, 32'h100);
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    tick();
    check_eq("rd_valid1", 32'(inst_valid), 32'h1);
    check_eq("rd_pc", inst_pc, 32'h100);
    check_eq("rd_inst", inst, mem_word(32'h100));
    tick();
    check_eq("rd_next_pc", inst_pc, 32'h104);

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("mis_valid", 32'(inst_valid), 32'h0);
    check_eq("mis_fault", 32'(misalign_fault), 32'h1);
    check_eq("mis_addr", imem_addr, 32'h108);
    tick();
    tick();
    check_eq("mis_hold_valid", 32'(inst_valid), 32'h0);
    check_eq("mis_hold_fault", 32'(misalign_fault), 32'h1);
    check_eq("mis_hold_addr", imem_addr, 32'h108);
`else
    check_eq("mis_valid", 32'(inst_valid), 32'h0);
    check_eq("mis_fault", 32'(misalign_fault), 32'h0);
    check_eq("mis_addr", imem_addr, 32'h100);
    tick();
    check_eq("mis_pc", inst_pc, 32'h100);
    check_eq("mis_valid1", 32'(inst_valid), 32'h1);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check_eq("al_valid", 32'(inst_valid), 32'h0);
    check_eq("al_fault", 32'(misalign_fault), 32'h0);
    check_eq("al_addr", imem_addr, 32'h200);
    tick();
    check_eq("al_pc", inst_pc, 32'h200);
    check_eq("al_valid1", 32'(inst_valid), 32'h1);
    tick();
    check_eq("al_next_pc", inst_pc, 32'h204);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_valid", 32'(inst_valid), 32'h0);
    check_eq("ar_inst", inst, 32'h0);
    check_eq("ar_inst_pc", inst_pc, 32'h0);
    check_eq("ar_fault", 32'(misalign_fault), 32'h0);
    check_eq("ar_addr", imem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_eq("ar_restart_pc", inst_pc, 32'h0);
    check_eq("ar_restart_valid", 32'(inst_valid), 32'h1);
    tick();
    check_eq("ar_next_pc", inst_pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
